vdp_io_fifo: RTL and testbench

- Buffers CPU I/O accesses between the Z80 bus decoder (CPU_IO) and the VDP register/port interface (REQ/WRT/DBI/DBO/ACK).
- CPU writes are posted into a FIFO, so bursts (e.g. VRAM fills on port 0x98) never depend on VDP access timing.
- Reads wait for all earlier posted writes to drain, then execute in order; the result is returned to CPU_IO.
- Runs entirely in the clk_w (pixel) domain.

---
 rtl/vdp_io_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/vdp_io_fifo.sv | 162 ++++++++++++++++
 tb/tb_vdp_io_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_io_pkg.sv
// rtl/vdp_io_pkg.sv - shared types for the VDP I/O posting FIFO
package vdp_io_pkg;

    typedef struct packed {
        logic       wr;
        logic [1:0] port;
        logic [7:0] data;
    } io_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } io_state_t;

    localparam int IO_ENTRY_W = $bits(io_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vdp_io_fifo.sv
// rtl/vdp_io_fifo.sv - posts CPU writes to the VDP through a FIFO, reads act as barriers; VDP_IO_FIFO_STATS_EN adds hwm/drop_cnt
module vdp_io_fifo
    import vdp_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_port,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_rd_valid,
    output logic        cpu_busy,
    output logic        overflow,
    output logic        vdp_req,
    output logic        vdp_wr,
    output logic [1:0]  vdp_port,
    output logic [7:0]  vdp_dbo,
    input  logic [7:0]  vdp_dbi,
    input  logic        vdp_ack
`ifdef VDP_IO_FIFO_STATS_EN
    ,
    output logic [AW:0] hwm,
    output logic [7:0]  drop_cnt
`endif
);

    io_state_t             state;
    io_state_t             state_nx;
    io_entry_t             push_entry;
    io_entry_t             head;
    logic [IO_ENTRY_W-1:0] head_bits;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;
    logic [AW:0]           barrier_cnt;
    logic                  rd_pend;
    logic [1:0]            rd_port;
    logic                  wr_req;
    logic                  rd_req;
    logic                  pop;
    logic                  drop;

    assign wr_req     = cpu_req && cpu_wr;
    assign rd_req     = cpu_req && !cpu_wr && !rd_pend;
    assign pop        = (state == WR_WAIT) && vdp_ack;
    assign drop       = wr_req && fifo_full && !pop;
    assign push_entry = '{wr: 1'b1, port: cpu_port, data: cpu_data_in};
    assign head       = io_entry_t'(head_bits);
    assign cpu_busy   = rd_pend;

    sync_fifo #(
        .WIDTH (IO_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_req),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        vdp_req  = 1'b0;
        vdp_wr   = 1'b0;
        vdp_port = '0;
        vdp_dbo  = '0;
        case (state)
            IDLE: begin
                // barrier_cnt counts entries queued ahead of the pending read.
                if (!fifo_empty && (!rd_pend || barrier_cnt != '0)) begin
                    state_nx = WR_ISSUE;
                end else if (rd_pend && barrier_cnt == '0) begin
                    state_nx = RD_ISSUE;
                end
            end
            WR_ISSUE, WR_WAIT: begin
                vdp_req  = 1'b1;
                vdp_wr   = head.wr;
                vdp_port = head.port;
                vdp_dbo  = head.data;
                if (state == WR_ISSUE) begin
                    state_nx = WR_WAIT;
                end else if (vdp_ack) begin
                    state_nx = IDLE;
                end
            end
            RD_ISSUE, RD_WAIT: begin
                vdp_req  = 1'b1;
                vdp_port = rd_port;
                if (state == RD_ISSUE) begin
                    state_nx = RD_WAIT;
                end else if (vdp_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend      <= 1'b0;
            rd_port      <= '0;
            barrier_cnt  <= '0;
            cpu_data_out <= '0;
            cpu_rd_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            cpu_rd_valid <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (rd_req) begin
                rd_pend     <= 1'b1;
                rd_port     <= cpu_port;
                barrier_cnt <= fifo_count - (AW+1)'(pop);
            end else if (rd_pend && pop && barrier_cnt != '0) begin
                barrier_cnt <= barrier_cnt - (AW+1)'(1);
            end
            if (state == RD_WAIT && vdp_ack) begin
                cpu_data_out <= vdp_dbi;
                cpu_rd_valid <= 1'b1;
                rd_pend      <= 1'b0;
            end
        end
    end

`ifdef VDP_IO_FIFO_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm      <= '0;
            drop_cnt <= '0;
        end else begin
            if (fifo_count > hwm) begin
                hwm <= fifo_count;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vdp_io_fifo.sv
// tb/tb_vdp_io_fifo.sv - self-checking bench for vdp_io_fifo with a queue-based reference model
module tb_vdp_io_fifo;
    import vdp_io_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       cpu_req     = 1'b0;
    logic       cpu_wr      = 1'b0;
    logic [1:0] cpu_port    = 2'd0;
    logic [7:0] cpu_data_in = 8'd0;
    logic [7:0] vdp_dbi     = 8'd0;
    logic       vdp_ack     = 1'b0;
    logic [7:0] cpu_data_out;
    logic       cpu_rd_valid;
    logic       cpu_busy;
    logic       overflow;
    logic       vdp_req;
    logic       vdp_wr;
    logic [1:0] vdp_port;
    logic [7:0] vdp_dbo;
`ifdef VDP_IO_FIFO_STATS_EN
    logic [AW:0] hwm;
    logic [7:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    vdp_io_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_port     (cpu_port),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_busy     (cpu_busy),
        .overflow     (overflow),
        .vdp_req      (vdp_req),
        .vdp_wr       (vdp_wr),
        .vdp_port     (vdp_port),
        .vdp_dbo      (vdp_dbo),
        .vdp_dbi      (vdp_dbi),
        .vdp_ack      (vdp_ack)
`ifdef VDP_IO_FIFO_STATS_EN
        ,
        .hwm          (hwm),
        .drop_cnt     (drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: program-ordered list of VDP transactions, plus FIFO occupancy in writes.
    io_entry_t  exp_q[$];
    int         occ          = 0;
    bit         model_busy   = 1'b0;
    bit         exp_overflow = 1'b0;
    int         exp_drops    = 0;
    logic [7:0] next_rd_data = 8'd0;
    bit         ack_wr       = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            occ          = 0;
            model_busy   = 1'b0;
            exp_overflow = 1'b0;
            exp_drops    = 0;
        end else begin
            if (vdp_ack && ack_wr) occ--;
            if (cpu_req && cpu_wr) begin
                if (occ < DEPTH) begin
                    exp_q.push_back('{wr: 1'b1, port: cpu_port, data: cpu_data_in});
                    occ++;
                end else begin
                    exp_overflow = 1'b1;
                    exp_drops++;
                end
            end else if (cpu_req && !model_busy) begin
                exp_q.push_back('{wr: 1'b0, port: cpu_port, data: next_rd_data});
                model_busy = 1'b1;
            end
            if (vdp_ack && !ack_wr) model_busy = 1'b0;
        end
    end

    // VDP responder: checks each new transaction against the model and acks after ack_delay cycles.
    int         ack_delay   = 1;
    int         wait_cnt    = 0;
    int         txn_cnt     = 0;
    bit         seen        = 1'b0;
    bit         auto_ack    = 1'b1;
    bit         prev_ack_rd = 1'b0;
    io_entry_t  cur;
    logic [7:0] rd_exp      = 8'd0;

    always @(negedge clk) begin
        if (!reset_n || !vdp_req) begin
            seen = 1'b0;
            if (auto_ack) begin
                vdp_ack = 1'b0;
                ack_wr  = 1'b0;
            end
            if (reset_n) begin
                if (prev_ack_rd) begin
                    chk("rd_valid_pulse", cpu_rd_valid, 1);
                    chk("rd_data", cpu_data_out, rd_exp);
                end else begin
                    chk("rd_valid_idle", cpu_rd_valid, 0);
                end
            end
            prev_ack_rd = 1'b0;
        end else if (!seen) begin
            seen     = 1'b1;
            wait_cnt = ack_delay;
            txn_cnt++;
            chk("txn_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("txn_fields", {vdp_wr, vdp_port, cur.wr ? vdp_dbo : 8'h00},
                    {cur.wr, cur.port, cur.wr ? cur.data : 8'h00});
            end
        end else if (auto_ack) begin
            if (wait_cnt > 0) wait_cnt--;
            if (wait_cnt == 0 && !vdp_ack) begin
                vdp_ack = 1'b1;
                ack_wr  = cur.wr;
                vdp_dbi = cur.wr ? 8'($urandom) : cur.data;
                if (!cur.wr) begin
                    prev_ack_rd = 1'b1;
                    rd_exp      = cur.data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cpu_busy", cpu_busy, model_busy);
            chk("overflow", overflow, exp_overflow);
`ifdef VDP_IO_FIFO_STATS_EN
            chk("drop_cnt", drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
`endif
        end
    end

    task automatic cpu_op(input logic wr, input logic [1:0] port, input logic [7:0] data);
        cpu_req     = 1'b1;
        cpu_wr      = wr;
        cpu_port    = port;
        cpu_data_in = data;
        @(negedge clk);
        cpu_req     = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (!(exp_q.size() == 0 && occ == 0 && !model_busy && !vdp_req) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < max_cyc, 1);
        @(negedge clk);
    endtask

    int base;
    int r;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_vdp_req", vdp_req, 0);
        chk("rst_vdp_fields", {vdp_wr, vdp_port, vdp_dbo}, 0);
        chk("rst_cpu_out", {cpu_data_out, cpu_rd_valid, cpu_busy, overflow}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // single write, 2-cycle latency, ack 3 cycles after vdp_req
        ack_delay = 3;
        base = txn_cnt;
        cpu_op(1'b1, 2'd1, 8'h8F);
        chk("wr_latency_c1", vdp_req, 0);
        @(negedge clk);
        chk("wr_latency_c2", vdp_req, 1);
        wait_idle(100);
        chk("t1_txn_cnt", txn_cnt - base, 1);

        // 16 back-to-back writes with slow VDP, then one dropped write
        ack_delay = 50;
        base = txn_cnt;
        for (int i = 0; i < 16; i++) cpu_op(1'b1, 2'd0, 8'(i));
        chk("t2_no_overflow", overflow, 0);
        cpu_op(1'b1, 2'd0, 8'h10);
        chk("t2_overflow", overflow, 1);
`ifdef VDP_IO_FIFO_STATS_EN
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_hwm", hwm, 16);
`endif
        ack_delay = 2;
        wait_idle(2000);
        chk("t2_txn_cnt", txn_cnt - base, 16);

        // read behind two posted writes
        base = txn_cnt;
        next_rd_data = 8'h5C;
        cpu_op(1'b1, 2'd0, 8'hAA);
        cpu_op(1'b1, 2'd0, 8'hBB);
        cpu_op(1'b0, 2'd1, 8'h00);
        chk("t3_busy", cpu_busy, 1);
        wait_idle(200);
        chk("t3_txn_cnt", txn_cnt - base, 3);
        chk("t3_data_hold", cpu_data_out, 8'h5C);

        // write issued while a read is pending stays behind it
        base = txn_cnt;
        ack_delay = 4;
        next_rd_data = 8'h3E;
        cpu_op(1'b0, 2'd2, 8'h00);
        cpu_op(1'b1, 2'd3, 8'h11);
        wait_idle(200);
        chk("t4_txn_cnt", txn_cnt - base, 2);

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst2_overflow", overflow, 0);

        // full FIFO: push coinciding with pop is accepted, a lone push is not
        auto_ack = 1'b0;
        ack_delay = 1;
        base = txn_cnt;
        for (int i = 0; i < 16; i++) cpu_op(1'b1, 2'd0, 8'($urandom));
        vdp_ack     = 1'b1;
        ack_wr      = 1'b1;
        cpu_req     = 1'b1;
        cpu_wr      = 1'b1;
        cpu_port    = 2'd2;
        cpu_data_in = 8'h77;
        @(negedge clk);
        vdp_ack = 1'b0;
        ack_wr  = 1'b0;
        cpu_req = 1'b0;
        chk("t5_no_overflow", overflow, 0);
        cpu_op(1'b1, 2'd0, 8'h99);
        chk("t5_still_full", overflow, 1);
        auto_ack = 1'b1;
        wait_idle(500);
        chk("t5_txn_cnt", txn_cnt - base, 17);

        // reset during WR_WAIT with five entries queued
        ack_delay = 60;
        for (int i = 0; i < 5; i++) cpu_op(1'b1, 2'd1, 8'(8'h40 + i));
        reset_n = 1'b0;
        #1;
        chk("t6_req_async_drop", vdp_req, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = txn_cnt;
        repeat (20) @(negedge clk);
        chk("t6_no_stale_txn", txn_cnt - base, 0);
        chk("t6_overflow_clr", overflow, 0);

        // randomized mix of writes, reads and idle cycles
        for (int i = 0; i < 400; i++) begin
            ack_delay = $urandom_range(1, 5);
            r = $urandom_range(0, 9);
            if (r < 5) begin
                cpu_op(1'b1, 2'($urandom), 8'($urandom));
            end else if (r < 7) begin
                next_rd_data = 8'($urandom);
                cpu_op(1'b0, 2'($urandom), 8'h00);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle(5000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
